isa_decode_pipe: RTL and testbench

Parametrised decode stage for the 16-bit RISC pipeline. It registers one fetched instruction per cycle under a valid/ready handshake and stall/flush control, and splits it into register fields, immediates and ALU controls, zeroing any field the opcode does not use. It keeps a DEPTH-stage delay line of register addresses and destination tags for the RR/EX/MEM/WB stages, and flags read-after-write hazards against it.

---
 rtl/isa_pkg.sv | 91 +++++++++
 rtl/reg_tag_delay.sv | 68 ++++++
 rtl/isa_decode_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_isa_decode_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the 16-bit RISC decode stage.
//   - default widths for the decode stage parameters
//   - opcode constants (OP_ADI .. OP_JRI)
//   - op_info(): per-opcode field usage, destination select and hazard sources
//   - is_legal(): opcode legality check
package isa_pkg;

   localparam int unsigned DEF_INSTR_W = 16;
   localparam int unsigned DEF_REG_W   = 3;
   localparam int unsigned DEF_DEPTH   = 3;
   localparam int unsigned DEF_IMM6_W  = 6;
   localparam int unsigned DEF_IMM9_W  = 9;
   localparam int unsigned OPC_W       = 4;

   localparam logic [OPC_W-1:0] OP_ADI  = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
   localparam logic [OPC_W-1:0] OP_NAND = 4'b0010;
   localparam logic [OPC_W-1:0] OP_LLI  = 4'b0011;
   localparam logic [OPC_W-1:0] OP_LW   = 4'b0100;
   localparam logic [OPC_W-1:0] OP_SW   = 4'b0101;
   localparam logic [OPC_W-1:0] OP_LM   = 4'b0110;
   localparam logic [OPC_W-1:0] OP_SM   = 4'b0111;
   localparam logic [OPC_W-1:0] OP_BEQ  = 4'b1000;
   localparam logic [OPC_W-1:0] OP_BLT  = 4'b1001;
   localparam logic [OPC_W-1:0] OP_BLE  = 4'b1010;
   localparam logic [OPC_W-1:0] OP_JAL  = 4'b1100;
   localparam logic [OPC_W-1:0] OP_JLR  = 4'b1101;
   localparam logic [OPC_W-1:0] OP_JRI  = 4'b1111;

   typedef enum logic [1:0] {DstNone, DstRa, DstRb, DstRc} dst_sel_e;
   typedef enum logic [1:0] {ImmNone, Imm6, Imm9} imm_sel_e;

   typedef struct packed {
      logic     use_ra;
      logic     use_rb;
      logic     use_rc;
      imm_sel_e imm;
      dst_sel_e dst;
      logic     src_a;   // ra is read by this opcode
      logic     src_b;   // rb is read by this opcode
   } op_info_t;

   function automatic logic is_legal(input logic [OPC_W-1:0] opcode);
      return (opcode != 4'b1011) && (opcode != 4'b1110);
   endfunction

   // Illegal opcodes fall to the all-zero default: no fields, no dst, no sources.
   function automatic op_info_t op_info(input logic [OPC_W-1:0] opcode);
      op_info_t info;
      info = '0;
      info.imm = ImmNone;
      info.dst = DstNone;
      case (opcode)
         OP_ADD, OP_NAND: begin
            info.use_ra = 1'b1; info.use_rb = 1'b1; info.use_rc = 1'b1;
            info.dst    = DstRc;
            info.src_a  = 1'b1; info.src_b  = 1'b1;
         end
         OP_ADI: begin
            info.use_ra = 1'b1; info.use_rb = 1'b1; info.imm = Imm6;
            info.dst    = DstRb;
            info.src_a  = 1'b1;
         end
         OP_LLI, OP_JAL: begin
            info.use_ra = 1'b1; info.imm = Imm9;
            info.dst    = DstRa;
         end
         OP_LW: begin
            info.use_ra = 1'b1; info.use_rb = 1'b1; info.imm = Imm6;
            info.dst    = DstRa;
            info.src_b  = 1'b1;
         end
         OP_SW, OP_BEQ, OP_BLT, OP_BLE: begin
            info.use_ra = 1'b1; info.use_rb = 1'b1; info.imm = Imm6;
            info.src_a  = 1'b1; info.src_b  = 1'b1;
         end
         OP_JLR: begin
            info.use_ra = 1'b1; info.use_rb = 1'b1;
            info.dst    = DstRa;
            info.src_b  = 1'b1;
         end
         OP_JRI, OP_LM, OP_SM: begin
            info.use_ra = 1'b1; info.imm = Imm9;
            info.src_a  = 1'b1;
         end
         default: info = '0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/reg_tag_delay.sv
// reg_tag_delay: DEPTH-stage shift line of register addresses and destination tags.
// Shifts on every rising clock edge; stage 0 takes the in_* values, stage k takes stage k-1.
// Ports:
//   clock, rst_n                    - clock, asynchronous active-low reset
//   in_ra, in_rb, in_rc, in_dst     - stage-0 register fields
//   in_we                           - stage-0 write-valid
//   pipe_ra/rb/rc/dst               - all stages, slice k = stage k
//   pipe_we                         - per-stage write-valid
module reg_tag_delay
   import isa_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned REG_W = DEF_REG_W
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic [REG_W-1:0]       in_ra,
   input  logic [REG_W-1:0]       in_rb,
   input  logic [REG_W-1:0]       in_rc,
   input  logic [REG_W-1:0]       in_dst,
   input  logic                   in_we,
   output logic [DEPTH*REG_W-1:0] pipe_ra,
   output logic [DEPTH*REG_W-1:0] pipe_rb,
   output logic [DEPTH*REG_W-1:0] pipe_rc,
   output logic [DEPTH*REG_W-1:0] pipe_dst,
   output logic [DEPTH-1:0]       pipe_we
);

   logic [REG_W-1:0] ra_q  [DEPTH];
   logic [REG_W-1:0] rb_q  [DEPTH];
   logic [REG_W-1:0] rc_q  [DEPTH];
   logic [REG_W-1:0] dst_q [DEPTH];
   logic             we_q  [DEPTH];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            ra_q[k]  <= '0;
            rb_q[k]  <= '0;
            rc_q[k]  <= '0;
            dst_q[k] <= '0;
            we_q[k]  <= 1'b0;
         end
      end else begin
         ra_q[0]  <= in_ra;
         rb_q[0]  <= in_rb;
         rc_q[0]  <= in_rc;
         dst_q[0] <= in_dst;
         we_q[0]  <= in_we;
         for (int k = 1; k < DEPTH; k++) begin
            ra_q[k]  <= ra_q[k-1];
            rb_q[k]  <= rb_q[k-1];
            rc_q[k]  <= rc_q[k-1];
            dst_q[k] <= dst_q[k-1];
            we_q[k]  <= we_q[k-1];
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_out
      assign pipe_ra[k*REG_W +: REG_W]  = ra_q[k];
      assign pipe_rb[k*REG_W +: REG_W]  = rb_q[k];
      assign pipe_rc[k*REG_W +: REG_W]  = rc_q[k];
      assign pipe_dst[k*REG_W +: REG_W] = dst_q[k];
      assign pipe_we[k]                 = we_q[k];
   end

endmodule

// File: rtl/isa_decode_pipe.sv
// isa_decode_pipe: decode stage of the 16-bit RISC pipeline.
// Registers one instruction per cycle (valid/ready with stall/flush), splits it into
// register fields, immediates and ALU controls (unused fields forced to 0), tracks the
// RR/EX/MEM/WB stages in a delay line and flags read-after-write hazards against it.
// Ports:
//   clock, rst_n                 - clock, asynchronous active-low reset
//   in_valid, in_instr, in_ready - fetch handshake (in_ready = !stall)
//   stall, flush                 - hold / discard control (flush wins)
//   out_valid, out_opcode        - decode register status and opcode
//   ra, rb, rc, imm6, imm9       - decoded fields
//   alu_and, alu_nand            - ALU controls
//   dst, dst_we, illegal         - destination, write flag, illegal opcode
//   raw_hazard                   - combinational RAW hazard flag
//   pipe_ra/rb/rc/dst, pipe_we   - delay line contents, slice k = stage k
module isa_decode_pipe
   import isa_pkg::*;
#(
   parameter int unsigned INSTR_W = DEF_INSTR_W,
   parameter int unsigned REG_W   = DEF_REG_W,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned IMM6_W  = DEF_IMM6_W,
   parameter int unsigned IMM9_W  = DEF_IMM9_W
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [INSTR_W-1:0]     in_instr,
   output logic                   in_ready,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [OPC_W-1:0]       out_opcode,
   output logic [REG_W-1:0]       ra,
   output logic [REG_W-1:0]       rb,
   output logic [REG_W-1:0]       rc,
   output logic [IMM6_W-1:0]      imm6,
   output logic [IMM9_W-1:0]      imm9,
   output logic                   alu_and,
   output logic                   alu_nand,
   output logic [REG_W-1:0]       dst,
   output logic                   dst_we,
   output logic                   illegal,
   output logic                   raw_hazard,
   output logic [DEPTH*REG_W-1:0] pipe_ra,
   output logic [DEPTH*REG_W-1:0] pipe_rb,
   output logic [DEPTH*REG_W-1:0] pipe_rc,
   output logic [DEPTH*REG_W-1:0] pipe_dst,
   output logic [DEPTH-1:0]       pipe_we
);

   // ---------------------------------------------------------------- field split
   logic [OPC_W-1:0]  in_opc;
   logic [REG_W-1:0]  f_ra, f_rb, f_rc;
   op_info_t          in_info;

   assign in_opc = in_instr[INSTR_W-1 -: OPC_W];
   assign f_ra   = in_instr[INSTR_W-OPC_W-1 -: REG_W];
   assign f_rb   = in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
   assign f_rc   = in_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];

   logic [REG_W-1:0]  dec_ra, dec_rb, dec_rc, dec_dst;
   logic [IMM6_W-1:0] dec_imm6;
   logic [IMM9_W-1:0] dec_imm9;
   logic              dec_and, dec_nand, dec_we, dec_illegal;

   always_comb begin
      in_info     = op_info(in_opc);
      dec_ra      = in_info.use_ra ? f_ra : '0;
      dec_rb      = in_info.use_rb ? f_rb : '0;
      dec_rc      = in_info.use_rc ? f_rc : '0;
      dec_imm6    = (in_info.imm == Imm6) ? in_instr[IMM6_W-1:0] : '0;
      dec_imm9    = (in_info.imm == Imm9) ? in_instr[IMM9_W-1:0] : '0;
      dec_dst     = '0;
      unique case (in_info.dst)
         DstRa:   dec_dst = f_ra;
         DstRb:   dec_dst = f_rb;
         DstRc:   dec_dst = f_rc;
         DstNone: dec_dst = '0;
      endcase
      dec_we      = (in_info.dst != DstNone);
      dec_and     = (in_opc == OP_ADD);
      dec_nand    = (in_opc == OP_NAND);
      dec_illegal = !is_legal(in_opc);
   end

   // ---------------------------------------------------------------- decode register
   logic              valid_q, valid_d, load_en;
   logic [OPC_W-1:0]  opcode_q;
   logic [REG_W-1:0]  ra_q, rb_q, rc_q, dst_q;
   logic [IMM6_W-1:0] imm6_q;
   logic [IMM9_W-1:0] imm9_q;
   logic              and_q, nand_q, we_q, illegal_q;

   assign in_ready = !stall;
   assign load_en  = !flush && !stall && in_valid;

   // flush > stall > load > drain; fields only change on a load.
   always_comb begin
      valid_d = valid_q;
      if (flush)         valid_d = 1'b0;
      else if (stall)    valid_d = valid_q;
      else if (in_valid) valid_d = 1'b1;
      else               valid_d = 1'b0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         opcode_q  <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         rc_q      <= '0;
         imm6_q    <= '0;
         imm9_q    <= '0;
         and_q     <= 1'b0;
         nand_q    <= 1'b0;
         dst_q     <= '0;
         we_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load_en) begin
            opcode_q  <= in_opc;
            ra_q      <= dec_ra;
            rb_q      <= dec_rb;
            rc_q      <= dec_rc;
            imm6_q    <= dec_imm6;
            imm9_q    <= dec_imm9;
            and_q     <= dec_and;
            nand_q    <= dec_nand;
            dst_q     <= dec_dst;
            we_q      <= dec_we;
            illegal_q <= dec_illegal;
         end
      end
   end

   assign out_valid  = valid_q;
   assign out_opcode = opcode_q;
   assign ra         = ra_q;
   assign rb         = rb_q;
   assign rc         = rc_q;
   assign imm6       = imm6_q;
   assign imm9       = imm9_q;
   assign alu_and    = and_q;
   assign alu_nand   = nand_q;
   assign dst        = dst_q;
   assign dst_we     = we_q;
   assign illegal    = illegal_q;

   // ---------------------------------------------------------------- delay line
   // The instruction leaves decode only when it is live and neither held nor flushed;
   // otherwise a bubble enters stage 0.
   logic             leave;
   logic [REG_W-1:0] st0_ra, st0_rb, st0_rc, st0_dst;
   logic             st0_we;

   assign leave   = valid_q && !stall && !flush;
   assign st0_ra  = leave ? ra_q  : '0;
   assign st0_rb  = leave ? rb_q  : '0;
   assign st0_rc  = leave ? rc_q  : '0;
   assign st0_dst = leave ? dst_q : '0;
   assign st0_we  = leave && we_q;

   reg_tag_delay #(
      .DEPTH (DEPTH),
      .REG_W (REG_W)
   ) u_delay (
      .clock    (clock),
      .rst_n    (rst_n),
      .in_ra    (st0_ra),
      .in_rb    (st0_rb),
      .in_rc    (st0_rc),
      .in_dst   (st0_dst),
      .in_we    (st0_we),
      .pipe_ra  (pipe_ra),
      .pipe_rb  (pipe_rb),
      .pipe_rc  (pipe_rc),
      .pipe_dst (pipe_dst),
      .pipe_we  (pipe_we)
   );

   // ---------------------------------------------------------------- hazard check
   // Unused fields are zero, so source flags are needed to avoid false r0 matches.
   op_info_t cur_info;
   logic     hit;

   always_comb begin
      cur_info = op_info(opcode_q);
      hit      = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (pipe_we[k]) begin
            if (cur_info.src_a && (ra_q == pipe_dst[k*REG_W +: REG_W])) hit = 1'b1;
            if (cur_info.src_b && (rb_q == pipe_dst[k*REG_W +: REG_W])) hit = 1'b1;
         end
      end
      raw_hazard = valid_q && hit;
   end

endmodule

// File: tb/tb_isa_decode_pipe.sv
// tb_isa_decode_pipe: directed + randomized bench for isa_decode_pipe with a
// reference model built from the opcode table.
module tb_isa_decode_pipe;

   localparam int unsigned IW = 16;
   localparam int unsigned RW = 3;
   localparam int unsigned DP = 3;
   localparam int unsigned I6 = 6;
   localparam int unsigned I9 = 9;

   logic              clock = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic [IW-1:0]     in_instr;
   logic              in_ready;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic [3:0]        out_opcode;
   logic [RW-1:0]     ra, rb, rc, dst;
   logic [I6-1:0]     imm6;
   logic [I9-1:0]     imm9;
   logic              alu_and, alu_nand, dst_we, illegal, raw_hazard;
   logic [DP*RW-1:0]  pipe_ra, pipe_rb, pipe_rc, pipe_dst;
   logic [DP-1:0]     pipe_we;

   always #5 clock = ~clock;

   isa_decode_pipe #(
      .INSTR_W (IW),
      .REG_W   (RW),
      .DEPTH   (DP),
      .IMM6_W  (I6),
      .IMM9_W  (I9)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .stall      (stall),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_opcode (out_opcode),
      .ra         (ra),
      .rb         (rb),
      .rc         (rc),
      .imm6       (imm6),
      .imm9       (imm9),
      .alu_and    (alu_and),
      .alu_nand   (alu_nand),
      .dst        (dst),
      .dst_we     (dst_we),
      .illegal    (illegal),
      .raw_hazard (raw_hazard),
      .pipe_ra    (pipe_ra),
      .pipe_rb    (pipe_rb),
      .pipe_rc    (pipe_rc),
      .pipe_dst   (pipe_dst),
      .pipe_we    (pipe_we)
   );

   // ---------------------------------------------------------------- reference model
   typedef struct packed {
      logic          v;
      logic [3:0]    op;
      logic [RW-1:0] ra, rb, rc;
      logic [I6-1:0] i6;
      logic [I9-1:0] i9;
      logic          an, nd;
      logic [RW-1:0] dst;
      logic          we, ill, sa, sb;
   } mdec_t;

   typedef struct packed {
      logic [RW-1:0] ra, rb, rc, dst;
      logic          we;
   } mstg_t;

   mdec_t m;
   mstg_t mp [DP];
   int    checks = 0;
   int    errors = 0;

   function automatic mdec_t ref_decode(input logic [IW-1:0] ins);
      mdec_t         d;
      logic [RW-1:0] a, b, c;
      d    = '0;
      a    = ins[IW-5 -: RW];
      b    = ins[IW-5-RW -: RW];
      c    = ins[IW-5-2*RW -: RW];
      d.v  = 1'b1;
      d.op = ins[IW-1 -: 4];
      case (d.op)
         4'h1, 4'h2: begin
            d.ra = a; d.rb = b; d.rc = c; d.dst = c; d.we = 1'b1;
            d.an = (d.op == 4'h1); d.nd = (d.op == 4'h2); d.sa = 1'b1; d.sb = 1'b1;
         end
         4'h0: begin
            d.ra = a; d.rb = b; d.i6 = ins[I6-1:0]; d.dst = b; d.we = 1'b1; d.sa = 1'b1;
         end
         4'h3, 4'hC: begin
            d.ra = a; d.i9 = ins[I9-1:0]; d.dst = a; d.we = 1'b1;
         end
         4'h4: begin
            d.ra = a; d.rb = b; d.i6 = ins[I6-1:0]; d.dst = a; d.we = 1'b1; d.sb = 1'b1;
         end
         4'h5, 4'h8, 4'h9, 4'hA: begin
            d.ra = a; d.rb = b; d.i6 = ins[I6-1:0]; d.sa = 1'b1; d.sb = 1'b1;
         end
         4'hD: begin
            d.ra = a; d.rb = b; d.dst = a; d.we = 1'b1; d.sb = 1'b1;
         end
         4'hF, 4'h6, 4'h7: begin
            d.ra = a; d.i9 = ins[I9-1:0]; d.sa = 1'b1;
         end
         default: d.ill = 1'b1;
      endcase
      return d;
   endfunction

   task automatic model_reset();
      m = '0;
      for (int k = 0; k < DP; k++) mp[k] = '0;
   endtask

   task automatic model_step(input logic v, input logic [IW-1:0] ins, input logic st,
                             input logic fl);
      for (int k = DP - 1; k > 0; k--) mp[k] = mp[k-1];
      mp[0] = '0;
      if (m.v && !st && !fl) begin
         mp[0].ra  = m.ra;
         mp[0].rb  = m.rb;
         mp[0].rc  = m.rc;
         mp[0].dst = m.dst;
         mp[0].we  = m.we;
      end
      if (fl)          m.v = 1'b0;
      else if (st)     m.v = m.v;
      else if (v)      m = ref_decode(ins);
      else             m.v = 1'b0;
   endtask

   function automatic logic model_hazard();
      logic h;
      h = 1'b0;
      if (m.v) begin
         for (int k = 0; k < DP; k++) begin
            if (mp[k].we && ((m.sa && mp[k].dst == m.ra) || (m.sb && mp[k].dst == m.rb)))
               h = 1'b1;
         end
      end
      return h;
   endfunction

   // ---------------------------------------------------------------- checking
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [DP*RW-1:0] e_ra, e_rb, e_rc, e_dst;
      logic [DP-1:0]    e_we;
      for (int k = 0; k < DP; k++) begin
         e_ra[k*RW +: RW]  = mp[k].ra;
         e_rb[k*RW +: RW]  = mp[k].rb;
         e_rc[k*RW +: RW]  = mp[k].rc;
         e_dst[k*RW +: RW] = mp[k].dst;
         e_we[k]           = mp[k].we;
      end
      chk("out_valid",  64'(out_valid),  64'(m.v));
      chk("out_opcode", 64'(out_opcode), 64'(m.op));
      chk("ra",         64'(ra),         64'(m.ra));
      chk("rb",         64'(rb),         64'(m.rb));
      chk("rc",         64'(rc),         64'(m.rc));
      chk("imm6",       64'(imm6),       64'(m.i6));
      chk("imm9",       64'(imm9),       64'(m.i9));
      chk("alu_and",    64'(alu_and),    64'(m.an));
      chk("alu_nand",   64'(alu_nand),   64'(m.nd));
      chk("dst",        64'(dst),        64'(m.dst));
      chk("dst_we",     64'(dst_we),     64'(m.we));
      chk("illegal",    64'(illegal),    64'(m.ill));
      chk("raw_hazard", 64'(raw_hazard), 64'(model_hazard()));
      chk("pipe_ra",    64'(pipe_ra),    64'(e_ra));
      chk("pipe_rb",    64'(pipe_rb),    64'(e_rb));
      chk("pipe_rc",    64'(pipe_rc),    64'(e_rc));
      chk("pipe_dst",   64'(pipe_dst),   64'(e_dst));
      chk("pipe_we",    64'(pipe_we),    64'(e_we));
   endtask

   // Called between edges: drive, check in_ready, clock once, check everything.
   task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic st,
                        input logic fl);
      in_valid = v;
      in_instr = ins;
      stall    = st;
      flush    = fl;
      #1;
      chk("in_ready", 64'(in_ready), 64'(!st));
      @(posedge clock);
      model_step(v, ins, st, fl);
      @(negedge clock);
      compare_all();
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid", 64'(out_valid),  64'(0));
      chk("rst_pipe_we",   64'(pipe_we),    64'(0));
      chk("rst_hazard",    64'(raw_hazard), 64'(0));
      compare_all();
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic          v, st, fl;
      logic [IW-1:0] ins;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      model_reset();
      @(negedge clock);
      compare_all();
      rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);

      // ADD r1,r2 -> r3, then track it into stage 2
      cycle(1'b1, 16'h1298, 1'b0, 1'b0);
      chk("add_valid", 64'(out_valid), 64'(1));
      chk("add_and",   64'(alu_and),   64'(1));
      chk("add_dst",   64'(dst),       64'(3));
      chk("add_we",    64'(dst_we),    64'(1));
      chk("add_imm6",  64'(imm6),      64'(0));
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
      chk("add_st2_dst", 64'(pipe_dst[2*RW +: RW]), 64'(3));
      chk("add_st2_we",  64'(pipe_we[2]),           64'(1));

      // LLI r5 followed by ADD reading r5
      cycle(1'b1, 16'h3A05, 1'b0, 1'b0);
      cycle(1'b1, 16'h1A40, 1'b0, 1'b0);
      chk("lli_add_hazard", 64'(raw_hazard), 64'(1));
      for (int i = 0; i < DP; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("hazard_cleared", 64'(raw_hazard), 64'(0));
      cycle(1'b0, '0, 1'b0, 1'b0);

      // BEQ held by a 2-cycle stall
      cycle(1'b1, 16'h8280, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 16'h1298, 1'b1, 1'b0);
         chk("stall_ra",     64'(ra),         64'(1));
         chk("stall_rb",     64'(rb),         64'(2));
         chk("stall_valid",  64'(out_valid),  64'(1));
         chk("stall_bubble", 64'(pipe_we[0]), 64'(0));
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < DP; i++) cycle(1'b0, '0, 1'b0, 1'b0);

      // Flush with SW offered; LLI already in the pipe must survive
      cycle(1'b1, 16'h3A05, 1'b0, 1'b0);
      cycle(1'b1, 16'h1298, 1'b0, 1'b0);
      cycle(1'b1, 16'h5281, 1'b0, 1'b1);
      chk("flush_valid",  64'(out_valid),           64'(0));
      chk("flush_st1",    64'(pipe_dst[1*RW +: RW]), 64'(5));
      chk("flush_st1_we", 64'(pipe_we[1]),          64'(1));
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("flush_pipe_we", 64'(pipe_we), 64'(3'b100));

      // Illegal opcodes
      cycle(1'b1, 16'hB000, 1'b0, 1'b0);
      chk("ill_b_flag", 64'(illegal), 64'(1));
      chk("ill_b_we",   64'(dst_we),  64'(0));
      cycle(1'b1, 16'hEFFF, 1'b0, 1'b0);
      chk("ill_e_flag", 64'(illegal), 64'(1));
      chk("ill_e_ra",   64'(ra),      64'(0));
      chk("ill_e_imm9", 64'(imm9),    64'(0));
      chk("ill_e_val",  64'(out_valid), 64'(1));

      // Mid-stream asynchronous reset
      cycle(1'b1, 16'h1298, 1'b0, 1'b0);
      cycle(1'b1, 16'h3A05, 1'b0, 1'b0);
      reset_pulse();
      cycle(1'b1, 16'h1298, 1'b0, 1'b0);

      // Randomized traffic with one reset in the middle
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 4) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         ins = 16'($urandom);
         if (i == 200) reset_pulse();
         cycle(v, ins, st, fl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
